free_running_counter: RTL and testbench
=======================================

Name: free_running_counter

Overview:
- Free-running synchronous binary up-counter with a parameterised width.
- Counts clock edges after reset release and wraps at a programmable terminal value.
- Used as a timebase / sequencing source and as the workshop's reference sequential block.
- No control inputs: the count advances on every rising clock edge while reset is deasserted.

Parameters:
- BW, 3, counter width in bits (legal range 1..32).
- MAX_VAL, 2**BW-1, terminal count. The counter wraps to 0 after this value. Must be ≤ 2**BW-1; a larger value is clamped to 2**BW-1 at elaboration.

Ports:
- clk_i  input  1  clock; rising-edge active.
- nrst_i  input  1  reset; asynchronous assertion, active-low (0 = reset).
- counter_val_o  output  BW  current count value, driven directly from a register (no combinational path from inputs).
- wrap_o  output  1  high for exactly one cycle while counter_val_o == MAX_VAL. Registered; may be left unconnected.

Behaviour:
- Interface (already decided): one clock, clk_i; reset nrst_i is asynchronous and active-low.
- Reset:
  - nrst_i = 0 immediately (no clock needed) forces counter_val_o = 0 and wrap_o = 0.
  - Outputs hold those values for as long as nrst_i stays low.
  - Reset asserted mid-count clears the count at once; no partial update.
- Reset release: release is treated synchronously. The first rising edge with nrst_i = 1 moves the count 0 -> 1.
- Counting:
  - On each rising clk_i edge with nrst_i = 1, if count < MAX_VAL then count <= count + 1, else count <= 0.
  - Arithmetic is unsigned, modulo 2**BW. No overflow outputs other than wrap_o.
- wrap_o:
  - Registered so that it equals 1 in exactly the cycle where counter_val_o == MAX_VAL, and 0 otherwise.
  - Period of wrap_o is MAX_VAL+1 cycles.
- Latency: one clock from edge to updated counter_val_o; wrap_o is cycle-aligned with counter_val_o.
- Degenerate case: MAX_VAL = 0 keeps counter_val_o at 0 permanently and holds wrap_o = 1 after the first post-reset edge.
- Simultaneous events: reset asserted coincident with a clock edge means reset wins; the output is 0.
- No X propagation: every output is defined from the first reset onward.

Optional Feature:
- Macro: COUNTER_GRAY_OUT_EN.
- When defined:
  - counter_val_o carries the Gray code of the internal binary count, bin ^ (bin >> 1), registered with no added latency.
  - The binary register is kept internally.
  - wrap_o still compares the binary count against MAX_VAL.
  - Reset value is 0.
  - For the full-range case (MAX_VAL = 2**BW-1), consecutive outputs differ in exactly one bit, including across the wrap.
- When undefined: counter_val_o is plain binary as described above.

Test Plan:
- Reset at power-up: hold nrst_i = 0 for 5 cycles -> counter_val_o = 0 and wrap_o = 0 throughout, with no clock dependence.
- Basic count, BW = 3, MAX_VAL = 7: release reset -> outputs 1,2,...,7 then 0,1. wrap_o = 1 only in the cycle showing 7.
- Truncated wrap, BW = 3, MAX_VAL = 5: run 14 cycles -> sequence 1,2,3,4,5,0,1,... wrap_o pulses every 6 cycles.
- Async reset mid-count: assert nrst_i between clock edges while the count is 4 -> counter_val_o = 0 before the next edge. Release -> counts resume 1,2,...
- Width scaling, BW = 8: run 260 cycles from reset -> value 255 then wraps to 0 (then 1, 2, ...). wrap_o pulses once per 256 cycles.
- With COUNTER_GRAY_OUT_EN, BW = 3: output sequence 001,011,010,110,111,101,100,000. Each step is a single-bit change, including the wrap.

Source files
------------

// File: rtl/free_running_counter.sv
// Free-running binary up-counter that wraps at a terminal value, with a one-cycle wrap_o flag.
// Define COUNTER_GRAY_OUT_EN to present the count on counter_val_o in Gray code.
module free_running_counter #(
  parameter int unsigned     BW      = 3,
  parameter longint unsigned MAX_VAL = (64'd1 << BW) - 64'd1
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  output logic [BW-1:0] counter_val_o,
  output logic          wrap_o
);

  // A terminal count that does not fit in BW bits is clamped to the all-ones value.
  localparam longint unsigned FULL_VAL = (64'd1 << BW) - 64'd1;
  localparam longint unsigned TERM_L   = (MAX_VAL > FULL_VAL) ? FULL_VAL : MAX_VAL;
  localparam logic [BW-1:0]   TERM     = TERM_L[BW-1:0];

  logic [BW-1:0] count_q, count_d;
  logic          wrap_q, wrap_d;

  // wrap_d looks at the next count so the registered flag lines up with the count it describes.
  always_comb begin
    count_d = (count_q == TERM) ? '0 : count_q + BW'(1);
    wrap_d  = (count_d == TERM);
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign wrap_o = wrap_q;

`ifdef COUNTER_GRAY_OUT_EN
  // The Gray register is loaded from the next binary count, so it adds no latency.
  logic [BW-1:0] gray_q, gray_d;

  always_comb begin
    gray_d = count_d ^ (count_d >> 1);
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_d;
    end
  end

  assign counter_val_o = gray_q;
`else
  assign counter_val_o = count_q;
`endif

endmodule

// File: tb/tb_free_running_counter.sv
// Scoreboard bench for free_running_counter: several parameterisations share one clock and reset.
// Expected values come from a small behavioural model, pushed per edge and popped after it.
module tb_free_running_counter;

   localparam int NDUT = 5;

   logic clk;
   logic nrst;
   logic clkEn;

   logic [2:0] val7, val5, val0, valClamp;
   logic [7:0] val8;
   logic       wrap7, wrap5, wrap8, wrap0, wrapClamp;

   // Instances: full range, truncated wrap, 8-bit width, degenerate terminal 0, clamped terminal.
   free_running_counter #(.BW(3)) dut7 (
      .clk_i(clk), .nrst_i(nrst), .counter_val_o(val7), .wrap_o(wrap7));
   free_running_counter #(.BW(3), .MAX_VAL(5)) dut5 (
      .clk_i(clk), .nrst_i(nrst), .counter_val_o(val5), .wrap_o(wrap5));
   free_running_counter #(.BW(8)) dut8 (
      .clk_i(clk), .nrst_i(nrst), .counter_val_o(val8), .wrap_o(wrap8));
   free_running_counter #(.BW(3), .MAX_VAL(0)) dut0 (
      .clk_i(clk), .nrst_i(nrst), .counter_val_o(val0), .wrap_o(wrap0));
   free_running_counter #(.BW(3), .MAX_VAL(20)) dutClamp (
      .clk_i(clk), .nrst_i(nrst), .counter_val_o(valClamp), .wrap_o(wrapClamp));

   logic [7:0] obsVal [NDUT];
   logic       obsWrap [NDUT];

   assign obsVal[0] = {5'b0, val7};
   assign obsVal[1] = {5'b0, val5};
   assign obsVal[2] = val8;
   assign obsVal[3] = {5'b0, val0};
   assign obsVal[4] = {5'b0, valClamp};
   assign obsWrap[0] = wrap7;
   assign obsWrap[1] = wrap5;
   assign obsWrap[2] = wrap8;
   assign obsWrap[3] = wrap0;
   assign obsWrap[4] = wrapClamp;

   // Clamped instance asked for 20 on a 3-bit counter, so it must behave as terminal 7.
   int unsigned maxVal [NDUT] = '{7, 5, 255, 0, 7};
   int unsigned model  [NDUT];

   typedef struct {
      int         idx;
      logic [7:0] val;
      logic       wrap;
   } exp_t;

   exp_t sb [$];

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] prevGray7;

   // Gated clock so the power-up reset can be checked with no edges at all.
   initial clk = 1'b0;
   always begin
      #5;
      if (clkEn) clk = ~clk;
   end

   function automatic logic [7:0] outCode(input int unsigned bin);
      logic [7:0] b;
      b = bin[7:0];
`ifdef COUNTER_GRAY_OUT_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model one edge, queue its predictions, then compare once the DUTs have updated.
   task automatic applyStimulus();
      exp_t e;
      for (int i = 0; i < NDUT; i++) begin
         model[i] = (model[i] == maxVal[i]) ? 0 : model[i] + 1;
         e.idx  = i;
         e.val  = outCode(model[i]);
         e.wrap = (model[i] == maxVal[i]);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput($sformatf("val[%0d]", e.idx), 32'(obsVal[e.idx]), 32'(e.val));
         checkOutput($sformatf("wrap[%0d]", e.idx), 32'(obsWrap[e.idx]), 32'(e.wrap));
      end
`ifdef COUNTER_GRAY_OUT_EN
      checkOutput("grayStep7", 32'($countones(prevGray7 ^ obsVal[0])), 32'd1);
      prevGray7 = obsVal[0];
`endif
   endtask

   task automatic checkAllReset(input string tag);
      for (int i = 0; i < NDUT; i++) begin
         checkOutput($sformatf("%s val[%0d]", tag, i), 32'(obsVal[i]), 32'd0);
         checkOutput($sformatf("%s wrap[%0d]", tag, i), 32'(obsWrap[i]), 32'd0);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < NDUT; i++) model[i] = 0;
      prevGray7 = 8'd0;
   endtask

   initial begin
      clkEn = 1'b0;
      nrst  = 1'b1;
      resetModel();

      // Reset must take effect with the clock stopped.
      #2 nrst = 1'b0;
      #1 checkAllReset("asyncNoClk");

      clkEn = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkAllReset("holdReset");
      end

      // Release away from the edge; the first rising edge then shows 1.
      nrst = 1'b1;
      for (int c = 0; c < 260; c++) applyStimulus();

      // Run until the full-range counter shows 4, then pull reset between edges.
      for (int c = 0; c < 16 && model[0] != 4; c++) applyStimulus();
      checkOutput("reachedFour", 32'(obsVal[0]), 32'(outCode(4)));
      #2 nrst = 1'b0;
      #1 checkAllReset("midCount");
      resetModel();
      @(posedge clk);
      #1 checkAllReset("lowAcrossEdge");

      @(negedge clk);
      nrst = 1'b1;
      for (int c = 0; c < 10; c++) applyStimulus();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
